uart_rx_hex_source: RTL and testbench

serial receiver that feeds the 8-bit hex_byte input of the seven-segment display stage with the last correctly framed byte.

Interface

---
 rtl/uart_rx_hex_source.sv | 152 +++++++++++++++
 tb/tb_uart_rx_hex_source.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_hex_source.sv
// 8N1 UART receiver with 16x oversampling; publishes the last correctly framed byte on hex_byte
// together with single-cycle data_valid / framing_error strobes.
module uart_rx_hex_source #(
  parameter int unsigned sys_clk_freq = 100000000,
  parameter int unsigned baud_rate    = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] hex_byte,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned tick_div = sys_clk_freq / (baud_rate * 16);
  // Clamp so a too-fast baud setting still yields a legal counter.
  localparam int unsigned TickDiv  = (tick_div < 1) ? 1 : tick_div;
  localparam int unsigned TickW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TickDiv - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  logic [1:0]       rst_sync_q;
  logic             rst_int_n;
  logic             rx_meta_q;
  logic             rx_sync_q;
  logic [TickW-1:0] tick_cnt_q;
  logic             tick;
  logic             start_det;
  state_e           state_q;
  logic [3:0]       sub_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       hex_byte_q;
  logic             data_valid_q;
  logic             framing_error_q;

  // Assert asynchronously, release synchronously to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign tick      = (tick_cnt_q == TickMax);
  assign start_det = (state_q == StIdle) && !rx_sync_q;

  // Restarting on the start edge puts every later sample at a fixed phase of the bit.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tick_cnt_q <= '0;
    end else if (start_det || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TickW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q         <= StIdle;
      sub_cnt_q       <= 4'd0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'h00;
      hex_byte_q      <= 8'h00;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_sync_q) begin
            state_q   <= StStart;
            sub_cnt_q <= 4'd0;
            bit_idx_q <= 3'd0;
          end
        end
        StStart: begin
          if (tick) begin
            if (sub_cnt_q == 4'd7) begin
              sub_cnt_q <= 4'd0;
              state_q   <= rx_sync_q ? StIdle : StData;
            end else begin
              sub_cnt_q <= sub_cnt_q + 4'd1;
            end
          end
        end
        StData: begin
          if (tick) begin
            sub_cnt_q <= sub_cnt_q + 4'd1;
            if (sub_cnt_q == 4'd15) begin
              shift_q[bit_idx_q] <= rx_sync_q;
              bit_idx_q          <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
                state_q <= StStop;
              end
            end
          end
        end
        StStop: begin
          if (tick) begin
            sub_cnt_q <= sub_cnt_q + 4'd1;
            if (sub_cnt_q == 4'd15) begin
              if (rx_sync_q) begin
                hex_byte_q   <= shift_q;
                data_valid_q <= 1'b1;
                state_q      <= StIdle;
              end else begin
                framing_error_q <= 1'b1;
                state_q         <= StBreak;
              end
            end
          end
        end
        StBreak: begin
          if (rx_sync_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hex_byte      = hex_byte_q;
  assign data_valid    = data_valid_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_hex_source.sv
// Self-checking bench for uart_rx_hex_source: table-driven frames plus hand-written corner cases,
// with a scoreboard of expected bytes consumed on each data_valid pulse.
module tb_uart_rx_hex_source;

  // Reduced clock keeps runtime short: 16x oversampling with 8 clk per tick.
  localparam int unsigned ClkHz = 14745600;
  localparam int unsigned Baud  = 115200;
  localparam int unsigned Tick  = ClkHz / (Baud * 16);
  localparam int unsigned Bit   = Tick * 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] hex_byte;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  uart_rx_hex_source #(
    .sys_clk_freq(ClkHz),
    .baud_rate   (Baud)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .hex_byte     (hex_byte),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .busy         (busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_byte;
    int         exp_dv;
    int         exp_fe;
  } vec_t;

  int         assert_cnt = 0;
  int         fail_cnt = 0;
  int         dv_count = 0;
  int         fe_count = 0;
  int         cyc = 0;
  int         fall_cyc = 0;
  logic [7:0] exp_q[$];
  int         dv_cyc_q[$];
  vec_t       vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    assert_cnt++;
    if (act < lo || act > hi) begin
      fail_cnt++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Drives start, 8 data bits LSB first and one stop bit; leaves rx at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (Bit) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Bit) @(negedge clk);
    end
    rx = stop_bit;
    repeat (Bit) @(negedge clk);
  endtask

  // Output monitor / scoreboard consumer.
  initial begin
    logic prev_dv;
    logic prev_fe;
    logic [7:0] exp_b;
    prev_dv = 1'b0;
    prev_fe = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (data_valid) begin
        dv_count++;
        dv_cyc_q.push_back(cyc);
        check("dv_with_fe", framing_error, 1'b0);
        check("dv_width", prev_dv, 1'b0);
        check("dv_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("sb_byte", hex_byte, exp_b);
        end
      end
      if (framing_error) begin
        fe_count++;
        check("fe_width", prev_fe, 1'b0);
      end
      prev_dv = data_valid;
      prev_fe = framing_error;
    end
  end

  initial begin
    int dv0;
    int fe0;
    int busy_cyc;
    int n0;
    int diff;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    vecs[3] = '{8'h3C, 1'b1, 8'h3C, 1, 0};
    vecs[4] = '{8'h7E, 1'b0, 8'h3C, 0, 1};
    vecs[5] = '{8'h81, 1'b1, 8'h81, 1, 0};

    repeat (5) @(negedge clk);
    check("rst_hex", hex_byte, 8'h00);
    check("rst_dv", data_valid, 1'b0);
    check("rst_fe", framing_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      dv0 = dv_count;
      fe0 = fe_count;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      rx = 1'b1;
      repeat (3 * Bit) @(negedge clk);
      check($sformatf("v%0d_dv", i), dv_count - dv0, vecs[i].exp_dv);
      check($sformatf("v%0d_fe", i), fe_count - fe0, vecs[i].exp_fe);
      check($sformatf("v%0d_hex", i), hex_byte, vecs[i].exp_byte);
      check($sformatf("v%0d_busy", i), busy, 1'b0);
      if (i == 0 && dv_cyc_q.size() != 0) begin
        check_range("latency", dv_cyc_q[dv_cyc_q.size() - 1] - fall_cyc,
                    152 * Tick, 152 * Tick + 6);
      end
    end

    // Short low pulse: mid-start sample sees high, FSM falls back to idle.
    dv0 = dv_count;
    fe0 = fe_count;
    busy_cyc = 0;
    rx = 1'b0;
    for (int k = 0; k < 4 * Bit; k++) begin
      if (k == 30) rx = 1'b1;
      @(negedge clk);
      if (busy) busy_cyc++;
    end
    check_range("glitch_busy", busy_cyc, 8 * Tick - 3, 8 * Tick + 3);
    check("glitch_dv", dv_count - dv0, 0);
    check("glitch_fe", fe_count - fe0, 0);
    check("glitch_hex", hex_byte, 8'h81);

    // Bad stop bit followed by a long low line.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    rx = 1'b1;
    repeat (2 * Bit) @(negedge clk);
    check("fr_pre_hex", hex_byte, 8'hA5);
    dv0 = dv_count;
    fe0 = fe_count;
    send_frame(8'h3C, 1'b0);
    repeat (2000) @(negedge clk);
    check("fr_fe", fe_count - fe0, 1);
    check("fr_dv", dv_count - dv0, 0);
    check("fr_break_hex", hex_byte, 8'hA5);
    check("fr_break_busy", busy, 1'b1);
    rx = 1'b1;
    repeat (Bit) @(negedge clk);
    check("fr_idle_busy", busy, 1'b0);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    repeat (3 * Bit) @(negedge clk);
    check("fr_next_hex", hex_byte, 8'h01);
    check("fr_next_dv", dv_count - dv0, 1);

    // Back-to-back frames, no idle between stop and next start.
    dv0 = dv_count;
    n0 = dv_cyc_q.size();
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    rx = 1'b1;
    repeat (3 * Bit) @(negedge clk);
    check("b2b_dv", dv_count - dv0, 2);
    check("b2b_hex", hex_byte, 8'h34);
    diff = (dv_cyc_q.size() >= n0 + 2) ? dv_cyc_q[n0 + 1] - dv_cyc_q[n0] : 0;
    check_range("b2b_spacing", diff, 10 * Bit - 2, 10 * Bit + 2);

    // Reset during data bit 4 of 0xFF.
    dv0 = dv_count;
    fe0 = fe_count;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (5 * Bit + Bit / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_hex", hex_byte, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    rx = 1'b1;
    repeat (2 * Bit) @(negedge clk);
    check("mid_rst_dv", dv_count - dv0, 0);
    check("mid_rst_fe", fe_count - fe0, 0);
    check("mid_rst_hold", hex_byte, 8'h00);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    rx = 1'b1;
    repeat (3 * Bit) @(negedge clk);
    check("post_rst_hex", hex_byte, 8'h5A);
    check("post_rst_dv", dv_count - dv0, 1);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
